fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch and program-counter stage of the SISC datapath, directly upstream of the control FSM.
- Holds PC and IR, fetches instructions from instruction memory over a req/ack handshake, and decodes the opcode/mm fields that the control FSM consumes.
- Executes the control FSM's PC commands (pc_rst, pc_write, pc_sel, br_sel) and evaluates branch conditions against the status flags.

Parameters:
ADDR_W, 16, PC / instruction-memory address width
INSTR_W, 32, instruction width (field positions below assume 32)
TIMEOUT, 15, max wait cycles for imem_ack (used only with FETCH_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all state on posedge
rst_f  in  1  synchronous active-low reset
pc_rst  in  1  from ctrl: synchronously clear PC to 0
pc_write  in  1  from ctrl: update PC this cycle
pc_sel  in  1  0 = sequential PC+1; 1 = branch target if condition true
br_sel  in  1  0 = relative target (PC+imm); 1 = absolute target (imm)
ir_load  in  1  from ctrl: start a fetch at the current PC
stat  in  4  status flags (C,N,V,Z) from status register
imem_req  out  1  instruction memory request
imem_addr  out  ADDR_W  request address, stable while imem_req=1
imem_ack  in  1  memory returns data this cycle
imem_rdata  in  INSTR_W  instruction data, valid with imem_ack
instr  out  INSTR_W  instruction register contents
opcode  out  4  instr[31:28]
mm  out  4  instr[27:24]
imm  out  16  instr[15:0]
pc  out  ADDR_W  current program counter
fetch_busy  out  1  fetch in flight (state != IDLE)
br_taken  out  1  registered: last pc_sel=1 update took the branch
fetch_err  out  1  sticky fetch-timeout flag

Behaviour:
- Reset (rst_f=0 at posedge): pc=0, instr=0 (NOOP), br_taken=0, fetch_err=0, imem_req=0, imem_addr=0, FSM=IDLE, timeout counter=0. Reset mid-fetch aborts it; imem_req is low in the cycle after the reset edge, and a late imem_ack is ignored.
- opcode/mm/imm are combinational slices of instr.
- FSM states:
  - IDLE: imem_req=0. On ir_load=1, latch imem_addr<=pc and go to REQ.
  - REQ: imem_req=1, imem_addr held. On imem_ack=1, instr<=imem_rdata and go to DONE. Otherwise stay.
  - DONE: imem_req=0 for one cycle, then IDLE.
- Fetch latency: at least 2 cycles from ir_load to instr valid; 0-wait memory updates instr at the 2nd posedge after ir_load sampled.
- ir_load while FSM != IDLE is ignored (no queueing).
- imem_ack in IDLE or DONE is ignored.
- PC update priority at each posedge: rst_f=0 first, then pc_rst (pc<=0, br_taken<=0), then pc_write, else hold.
  - pc_write & !pc_sel: pc<=pc+1; br_taken unchanged.
  - pc_write & pc_sel: if cond then pc<=target, else hold; br_taken<=cond.
- Branch condition (uses current instr):
  - opcode 4 (BRA) or 5 (BRR): cond = |(stat & mm).
  - opcode 6 (BNE) or 7 (BNR): cond = ~|(stat & mm).
  - Any other opcode: cond=0.
- Target:
  - br_sel=1: imm zero-extended/truncated to ADDR_W.
  - br_sel=0: pc + sign-extended imm.
  - Arithmetic is modulo 2^ADDR_W; PC+1 at max address wraps to 0.
- pc_write during a fetch is allowed. The in-flight imem_addr is unaffected because it was latched at request.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined: a counter clears on entering REQ and increments each REQ cycle without imem_ack. When it reaches TIMEOUT, the fetch is abandoned: instr<=0 (NOOP), fetch_err<=1, FSM goes to DONE.
  - fetch_err is sticky until rst_f=0 or pc_rst=1.
  - imem_ack in the same cycle the timeout is reached wins: data is loaded and there is no error.
- Not defined: REQ waits indefinitely, fetch_err is tied 0, and no counter is synthesized.

Test Plan:
- Reset then ir_load with 0-wait memory returning 32'h8123_4005 at addr 0 -> imem_addr=0, instr=32'h81234005, opcode=8, mm=1, imm=16'h4005 two cycles after ir_load; fetch_busy high for 2 cycles.
- pc=16'hFFFF, pc_write=1, pc_sel=0 -> pc=0 (wrap).
- instr opcode=5 (BRR), mm=4'b0001, stat=4'b0001, imm=16'hFFFE, pc=10, pc_write=1, pc_sel=1, br_sel=0 -> pc=8, br_taken=1. Same with stat=0 -> pc stays 10, br_taken=0.
- opcode=6 (BNE), mm=4'b0001, stat=0, imm=16'h0040, br_sel=1, pc_sel=1, pc_write=1 -> pc=16'h0040, br_taken=1. pc_rst=1 together with pc_write=1 -> pc=0.
- Memory with 3 wait cycles, rst_f driven low in the 2nd REQ cycle -> next cycle imem_req=0, instr=0, pc=0; a late ack is ignored. A second ir_load while busy is ignored.
- FETCH_TIMEOUT_EN, TIMEOUT=15, memory never acks -> after 15 REQ cycles instr=0, fetch_err=1, FSM returns to IDLE. fetch_err stays 1 until pc_rst=1.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC/IR holder, req/ack instruction fetch FSM, branch evaluation for the SISC control FSM.
// Latency: instr updates 2 posedges after ir_load is sampled with a 0-wait memory (+1 per wait cycle).
// Backpressure: holds imem_req/imem_addr until imem_ack; ir_load while busy is dropped, not queued.
// Optional macro FETCH_TIMEOUT_EN: abandon a fetch after TIMEOUT unacknowledged REQ cycles (sticky fetch_err).
module fetch_unit #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 32,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_f,
  input  logic               pc_rst,
  input  logic               pc_write,
  input  logic               pc_sel,
  input  logic               br_sel,
  input  logic               ir_load,
  input  logic [3:0]         stat,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [3:0]         mm,
  output logic [15:0]        imm,
  output logic [ADDR_W-1:0]  pc,
  output logic               fetch_busy,
  output logic               br_taken,
  output logic               fetch_err
);

  // Field slicing below hard-codes a 32-bit instruction layout.
  if (INSTR_W != 32 || TIMEOUT < 1) begin : g_bad_cfg
    $error("fetch_unit: INSTR_W must be 32 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_imem_req;
  logic [ADDR_W-1:0]   r_imem_addr;
  logic [INSTR_W-1:0]  r_instr;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_br_taken;

  logic                w_cond;
  logic [3:0]          w_flags;
  logic [ADDR_W-1:0]   w_imm_sx;
  logic [ADDR_W-1:0]   w_imm_zx;
  logic [ADDR_W-1:0]   w_target;
  logic [ADDR_W-1:0]   w_pc_inc;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0]    r_tmo_cnt;
  logic                r_fetch_err;
`endif

  assign opcode     = r_instr[31:28];
  assign mm         = r_instr[27:24];
  assign imm        = r_instr[15:0];
  assign instr      = r_instr;
  assign pc         = r_pc;
  assign imem_req   = r_imem_req;
  assign imem_addr  = r_imem_addr;
  assign br_taken   = r_br_taken;
  assign fetch_busy = (r_state != S_IDLE);

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err  = r_fetch_err;
`else
  assign fetch_err  = 1'b0;
`endif

  // Branch condition from current opcode: BRA/BRR take on any selected flag set, BNE/BNR on none set.
  always_comb begin
    w_cond  = 1'b0;
    w_flags = stat & mm;
    case (opcode)
      4'd4, 4'd5: w_cond = |w_flags;
      4'd6, 4'd7: w_cond = ~|w_flags;
      default:    w_cond = 1'b0;
    endcase
  end

  // Immediate extension to PC width (sign for relative, zero for absolute); truncates if ADDR_W < 16.
  always_comb begin
    w_imm_sx = '0;
    w_imm_zx = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (i < 16) begin
        w_imm_sx[i] = imm[i];
        w_imm_zx[i] = imm[i];
      end else begin
        w_imm_sx[i] = imm[15];
        w_imm_zx[i] = 1'b0;
      end
    end
  end

  assign w_target = br_sel ? w_imm_zx : (r_pc + w_imm_sx);
  assign w_pc_inc = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};

  // PC and branch-taken flag: reset, then pc_rst, then pc_write; wraps modulo 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      r_pc       <= '0;
      r_br_taken <= 1'b0;
    end else if (pc_rst) begin
      r_pc       <= '0;
      r_br_taken <= 1'b0;
    end else if (pc_write) begin
      if (!pc_sel) begin
        r_pc <= w_pc_inc;
      end else begin
        if (w_cond) r_pc <= w_target;
        r_br_taken <= w_cond;
      end
    end
  end

  // Fetch FSM with registered request/address and IR; address is latched at request so PC may move freely.
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      r_state     <= S_IDLE;
      r_imem_req  <= 1'b0;
      r_imem_addr <= '0;
      r_instr     <= '0;
`ifdef FETCH_TIMEOUT_EN
      r_tmo_cnt   <= '0;
      r_fetch_err <= 1'b0;
`endif
    end else begin
`ifdef FETCH_TIMEOUT_EN
      // A timeout in this same cycle still sets the flag since it is assigned later.
      if (pc_rst) r_fetch_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (ir_load) begin
            r_imem_addr <= r_pc;
            r_imem_req  <= 1'b1;
            r_state     <= S_REQ;
`ifdef FETCH_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
          end
        end
        S_REQ: begin
          if (imem_ack) begin
            r_instr    <= imem_rdata;
            r_imem_req <= 1'b0;
            r_state    <= S_DONE;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (r_tmo_cnt == TMO_LAST) begin
            r_instr     <= '0;
            r_fetch_err <= 1'b1;
            r_imem_req  <= 1'b0;
            r_state     <= S_DONE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors for fetch_unit with a small wait-state instruction memory model.
// Inputs driven 1 time unit after posedge, outputs sampled at the same point; memory answers on negedge.
// Build with +define+FETCH_TIMEOUT_EN to exercise the timeout path.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_f = 1'b0;
  logic        pc_rst = 1'b0;
  logic        pc_write = 1'b0;
  logic        pc_sel = 1'b0;
  logic        br_sel = 1'b0;
  logic        ir_load = 1'b0;
  logic [3:0]  stat = 4'h0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic [15:0] imm;
  logic [15:0] pc;
  logic        fetch_busy;
  logic        br_taken;
  logic        fetch_err;

  int          n_cmp = 0;
  int          n_err = 0;
  int          mem_wait = -1;
  int          req_cnt = 0;
  logic [31:0] mem_data = 32'h0;
  logic        stray = 1'b0;

  fetch_unit #(.ADDR_W(16), .INSTR_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst_f(rst_f), .pc_rst(pc_rst), .pc_write(pc_write), .pc_sel(pc_sel),
    .br_sel(br_sel), .ir_load(ir_load), .stat(stat), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .opcode(opcode), .mm(mm), .imm(imm), .pc(pc), .fetch_busy(fetch_busy),
    .br_taken(br_taken), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Memory model: acks in the (mem_wait+1)-th request cycle; mem_wait < 0 never acks; stray forces an ack.
  always @(negedge clk) begin
    if (stray) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_data;
    end else if (imem_req) begin
      if (mem_wait >= 0 && req_cnt == mem_wait) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_data;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0BAD_0BAD;
      end
      req_cnt++;
    end else begin
      imem_ack = 1'b0;
      req_cnt  = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] d);
    mem_wait = 0;
    mem_data = d;
    ir_load  = 1'b1;
    step();
    ir_load  = 1'b0;
    step();
    step();
  endtask

  task automatic do_br(input logic [3:0] s, input logic bs);
    stat     = s;
    br_sel   = bs;
    pc_sel   = 1'b1;
    pc_write = 1'b1;
    step();
    pc_write = 1'b0;
    pc_sel   = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    step();
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_req", imem_req, 32'h0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_busy", fetch_busy, 32'h0);
    check_eq("rst_brt", br_taken, 32'h0);
    check_eq("rst_err", fetch_err, 32'h0);
    rst_f = 1'b1;

    // 0-wait fetch; ir_load held through REQ and DONE must not restart a fetch
    mem_wait = 0;
    mem_data = 32'h8123_4005;
    ir_load  = 1'b1;
    step();
    check_eq("f0_busy1", fetch_busy, 32'h1);
    check_eq("f0_req1", imem_req, 32'h1);
    check_eq("f0_addr", imem_addr, 32'h0);
    check_eq("f0_instr_early", instr, 32'h0);
    step();
    check_eq("f0_instr", instr, 32'h8123_4005);
    check_eq("f0_opcode", opcode, 32'h8);
    check_eq("f0_mm", mm, 32'h1);
    check_eq("f0_imm", imm, 32'h4005);
    check_eq("f0_busy2", fetch_busy, 32'h1);
    check_eq("f0_req2", imem_req, 32'h0);
    step();
    ir_load = 1'b0;
    check_eq("f0_idle_busy", fetch_busy, 32'h0);
    check_eq("f0_idle_req", imem_req, 32'h0);

    // PC wrap: absolute BRA to FFFF then sequential increment
    do_fetch(32'h4100_FFFF);
    do_br(4'b0001, 1'b1);
    check_eq("bra_abs_pc", pc, 32'hFFFF);
    check_eq("bra_abs_brt", br_taken, 32'h1);
    pc_write = 1'b1;
    step();
    pc_write = 1'b0;
    check_eq("wrap_pc", pc, 32'h0);
    check_eq("wrap_brt_hold", br_taken, 32'h1);

    // BRR relative backwards by 2 from pc=10
    do_fetch(32'h4100_000A);
    do_br(4'b0001, 1'b1);
    check_eq("set_pc10", pc, 32'h000A);
    do_fetch(32'h5100_FFFE);
    do_br(4'b0001, 1'b0);
    check_eq("brr_pc", pc, 32'h0008);
    check_eq("brr_brt", br_taken, 32'h1);
    do_br(4'b0000, 1'b0);
    check_eq("brr_nt_pc", pc, 32'h0008);
    check_eq("brr_nt_brt", br_taken, 32'h0);

    // BNE absolute: flag set -> not taken, flag clear -> taken
    do_fetch(32'h6100_0040);
    do_br(4'b0001, 1'b1);
    check_eq("bne_nt_pc", pc, 32'h0008);
    check_eq("bne_nt_brt", br_taken, 32'h0);
    do_br(4'b0000, 1'b1);
    check_eq("bne_pc", pc, 32'h0040);
    check_eq("bne_brt", br_taken, 32'h1);

    // Non-branch opcode never branches
    do_fetch(32'h8F00_0003);
    do_br(4'hF, 1'b1);
    check_eq("nobr_pc", pc, 32'h0040);
    check_eq("nobr_brt", br_taken, 32'h0);

    // BNR relative +2, then pc_rst beats pc_write
    do_fetch(32'h7100_0002);
    do_br(4'b0000, 1'b0);
    check_eq("bnr_pc", pc, 32'h0042);
    check_eq("bnr_brt", br_taken, 32'h1);
    pc_rst = 1'b1; pc_write = 1'b1; pc_sel = 1'b1;
    step();
    pc_rst = 1'b0; pc_write = 1'b0; pc_sel = 1'b0;
    check_eq("pcrst_pc", pc, 32'h0);
    check_eq("pcrst_brt", br_taken, 32'h0);

    // 3-wait fetch, pc_write mid-fetch, reset in 2nd REQ cycle, then a stray ack
    mem_wait = 3;
    mem_data = 32'hDEAD_BEEF;
    ir_load  = 1'b1;
    step();
    pc_write = 1'b1;
    step();
    ir_load  = 1'b0;
    pc_write = 1'b0;
    check_eq("mid_addr", imem_addr, 32'h0);
    check_eq("mid_pc", pc, 32'h1);
    check_eq("mid_req", imem_req, 32'h1);
    rst_f = 1'b0;
    step();
    rst_f = 1'b1;
    check_eq("abort_req", imem_req, 32'h0);
    check_eq("abort_instr", instr, 32'h0);
    check_eq("abort_pc", pc, 32'h0);
    check_eq("abort_busy", fetch_busy, 32'h0);
    stray = 1'b1;
    step();
    stray = 1'b0;
    step();
    check_eq("stray_instr", instr, 32'h0);
    check_eq("stray_busy", fetch_busy, 32'h0);

    // Complete 3-wait fetch: data lands on the 5th posedge after ir_load
    mem_wait = 3;
    ir_load  = 1'b1;
    step();
    ir_load  = 1'b0;
    step(); step(); step();
    check_eq("w3_instr_early", instr, 32'h0);
    check_eq("w3_req", imem_req, 32'h1);
    step();
    check_eq("w3_instr", instr, 32'hDEAD_BEEF);
    step();
    step();

`ifdef FETCH_TIMEOUT_EN
    // Memory never acks: abandon after 15 REQ cycles
    mem_wait = -1;
    ir_load  = 1'b1;
    step();
    ir_load  = 1'b0;
    repeat (14) step();
    check_eq("tmo_req_pre", imem_req, 32'h1);
    check_eq("tmo_err_pre", fetch_err, 32'h0);
    step();
    check_eq("tmo_req", imem_req, 32'h0);
    check_eq("tmo_instr", instr, 32'h0);
    check_eq("tmo_err", fetch_err, 32'h1);
    step();
    check_eq("tmo_idle", fetch_busy, 32'h0);
    pc_write = 1'b1;
    step();
    pc_write = 1'b0;
    check_eq("tmo_sticky", fetch_err, 32'h1);
    pc_rst = 1'b1;
    step();
    pc_rst = 1'b0;
    check_eq("tmo_clr", fetch_err, 32'h0);
    // Ack arriving in the timeout cycle wins
    mem_wait = 14;
    mem_data = 32'hCAFE_F00D;
    ir_load  = 1'b1;
    step();
    ir_load  = 1'b0;
    repeat (15) step();
    check_eq("tmo_ack_instr", instr, 32'hCAFE_F00D);
    check_eq("tmo_ack_err", fetch_err, 32'h0);
    step();
    step();
`else
    // No timeout: request stays up indefinitely, no error
    mem_wait = -1;
    ir_load  = 1'b1;
    step();
    ir_load  = 1'b0;
    repeat (20) step();
    check_eq("wait_busy", fetch_busy, 32'h1);
    check_eq("wait_req", imem_req, 32'h1);
    check_eq("wait_err", fetch_err, 32'h0);
    rst_f = 1'b0;
    step();
    rst_f = 1'b1;
    check_eq("wait_rst_busy", fetch_busy, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
